// File: rtl/logic16_pipe_unit.sv
// logic16_pipe_unit
//
// Registered bitwise logic unit with a single output pipeline stage,
// a valid/ready handshake on both sides, and a wrapping transaction counter.
// This unit replaces the old combinational 16-bit AND gate in the Hack-style datapath.
//
// Parameters:
//   WIDTH  operand/result width in bits (>=1)
//   CNT_W  transaction counter width in bits (>=1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active-low
//   in_valid   operands/op valid
//   in_ready   unit can accept this cycle (combinational)
//   op         0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a, 7 ACC_AND
//   a, b       operands
//   acc_clr    return the accumulator to all-ones
//   out_valid  result register holds valid data
//   out_ready  consumer accepts the result
//   result     registered result
//   txn_count  count of accepted transactions, wraps
//   zr, ng     result==0 / result MSB (tied to 0 unless LOGIC_FLAGS_EN)
//
// Optional build macro: LOGIC_FLAGS_EN
//   When defined, zr/ng are registered alongside the result.
//   When undefined, zr/ng are constant 0 and no flag registers exist.

module logic16_pipe_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] txn_count,
    output logic             zr,
    output logic             ng
);

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_ACC   = 3'd7
    } op_t;

    logic             accept;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result_next;

    // The register can take new data when it is empty or is being drained now.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // A clear in the same cycle as an accumulate applies first, so the
    // accumulate then starts from all-ones and yields plain a.
    assign acc_base = acc_clr ? {WIDTH{1'b1}} : acc;
    assign acc_next = acc_base & a;

    always_comb begin
        result_next = '0;
        case (op_t'(op))
            OP_AND:  result_next = a & b;
            OP_OR:   result_next = a | b;
            OP_XOR:  result_next = a ^ b;
            OP_NAND: result_next = ~(a & b);
            OP_NOR:  result_next = ~(a | b);
            OP_XNOR: result_next = ~(a ^ b);
            OP_NOTA: result_next = ~a;
            OP_ACC:  result_next = acc_next;
            default: result_next = '0;
        endcase
    end

    // The output stage loads on accept, otherwise it empties once drained.
    // While stalled, nothing is loaded, so the result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            txn_count <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                result    <= result_next;
                txn_count <= txn_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // The accumulator moves only on an accepted ACC_AND, or on a standalone clear.
    // A clear still takes effect while the output stage is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= {WIDTH{1'b1}};
        end else if (accept && (op_t'(op) == OP_ACC)) begin
            acc <= acc_next;
        end else if (acc_clr) begin
            acc <= {WIDTH{1'b1}};
        end
    end

`ifdef LOGIC_FLAGS_EN
    // The flags follow the same load and hold rules as the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zr <= 1'b0;
            ng <= 1'b0;
        end else if (accept) begin
            zr <= (result_next == '0);
            ng <= result_next[WIDTH-1];
        end
    end
`else
    assign zr = 1'b0;
    assign ng = 1'b0;
`endif

endmodule

// File: tb/tb_logic16_pipe_unit.sv
// tb_logic16_pipe_unit
//
// Scoreboard bench for logic16_pipe_unit (WIDTH=16, CNT_W=8).
// Each accepted transaction pushes its expected result, count and flags.
// The monitor pops an entry whenever the output handshake completes.
// The monitor also tracks the expected out_valid and in_ready on every cycle.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled on the falling edge.

module tb_logic16_pipe_unit;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             acc_clr = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] txn_count;
    logic             zr;
    logic             ng;

    logic16_pipe_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .txn_count (txn_count),
        .zr        (zr),
        .ng        (ng)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [CNT_W-1:0] cnt;
        logic             zr;
        logic             ng;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               failures = 0;
    logic [CNT_W-1:0] expCount = '0;
    logic             mValid = 1'b0;
    int               cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] logicModel(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return '0;
        endcase
    endfunction

    function automatic exp_t makeExp(input logic [WIDTH-1:0] res, input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.res = res;
        e.cnt = cnt;
`ifdef LOGIC_FLAGS_EN
        e.zr  = (res == '0);
        e.ng  = res[WIDTH-1];
`else
        e.zr  = 1'b0;
        e.ng  = 1'b0;
`endif
        return e;
    endfunction

    // Present one transaction and hold it until it is accepted or the bound expires.
    // On acceptance, record the expected outcome.
    task automatic applyStimulus(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic clr, input logic [WIDTH-1:0] expRes);
        bit accepted;
        accepted = 0;
        op = o; a = x; b = y; acc_clr = clr; in_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) accepted = 1;
        end
        if (!accepted) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end else begin
            expCount = expCount + 1'b1;
            sb.push_back(makeExp(expRes, expCount));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_clr = 1'b0;
    endtask

    // Monitor: check the handshake every cycle, and pop the scoreboard on each output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mValid <= 1'b0;
        end else begin
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mValid});
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (!mValid || out_ready)});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("result", {16'd0, result}, {16'd0, e.res});
                    checkOutput("txn_count", {24'd0, txn_count}, {24'd0, e.cnt});
                    checkOutput("zr", {31'd0, zr}, {31'd0, e.zr});
                    checkOutput("ng", {31'd0, ng}, {31'd0, e.ng});
                end
            end
            if (in_valid && (!mValid || out_ready)) mValid <= 1'b1;
            else if (out_ready) mValid <= 1'b0;
        end
    end

    initial begin
        int startCyc;
        logic [2:0]       ro;
        logic [WIDTH-1:0] rx;
        logic [WIDTH-1:0] ry;

        // Reset state
        @(negedge clk);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_result", {16'd0, result}, 32'd0);
        checkOutput("rst_txn_count", {24'd0, txn_count}, 32'd0);
        checkOutput("rst_zr", {31'd0, zr}, 32'd0);
        checkOutput("rst_ng", {31'd0, ng}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // AND with a zero mask, then with an all-ones mask
        applyStimulus(3'd0, 16'h02F3, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(3'd0, 16'h02F3, 16'hFFFF, 1'b0, 16'h02F3);

        // The remaining fixed ops
        applyStimulus(3'd1, 16'hF0F0, 16'hFF00, 1'b0, 16'hFFF0);
        applyStimulus(3'd2, 16'hF0F0, 16'hFF00, 1'b0, 16'h0FF0);
        applyStimulus(3'd3, 16'hF0F0, 16'hFF00, 1'b0, 16'h0FFF);
        applyStimulus(3'd4, 16'hF0F0, 16'hFF00, 1'b0, 16'h000F);
        applyStimulus(3'd5, 16'hF0F0, 16'hFF00, 1'b0, 16'hF00F);
        applyStimulus(3'd6, 16'hF0F0, 16'hFF00, 1'b0, 16'h0F0F);

        // Accumulate from the reset value, then clear together with an accumulate
        applyStimulus(3'd7, 16'hFF0F, 16'h0000, 1'b0, 16'hFF0F);
        applyStimulus(3'd7, 16'h0FFF, 16'h0000, 1'b0, 16'h0F0F);
        applyStimulus(3'd7, 16'h1234, 16'h0000, 1'b1, 16'h1234);

        // Stall: hold a pending op while the consumer refuses, and clear acc meanwhile
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(3'd0, 16'hAAAA, 16'hAAAA, 1'b0, 16'hAAAA);
        op = 3'd1; a = 16'h0F0F; b = 16'hF0F0; in_valid = 1'b1; acc_clr = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("stall_result", {16'd0, result}, 32'h0000AAAA);
            checkOutput("stall_txn_count", {24'd0, txn_count}, {24'd0, expCount});
            @(posedge clk); #1;
            acc_clr = 1'b0;
        end
        out_ready = 1'b1;
        applyStimulus(3'd1, 16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF);
        // The clear during the stall leaves acc at all-ones
        applyStimulus(3'd7, 16'hF00F, 16'h0000, 1'b0, 16'hF00F);

        // Reset while a result is stalled
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(3'd0, 16'h0001, 16'h0001, 1'b0, 16'h0001);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        expCount = '0;
        @(negedge clk);
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_txn_count", {24'd0, txn_count}, 32'd0);
        checkOutput("midrst_result", {16'd0, result}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Counter wrap: 256 back-to-back accepts starting from 0
        startCyc = cyc;
        for (int i = 0; i < 256; i++) begin
            ro = 3'($urandom_range(0, 6));
            rx = 16'($urandom);
            ry = 16'($urandom);
            applyStimulus(ro, rx, ry, 1'b0, logicModel(ro, rx, ry));
        end
        checkOutput("wrap_cycles", startCyc + 256, cyc);
        @(negedge clk);
        checkOutput("wrap_txn_count", {24'd0, txn_count}, 32'd0);
        @(posedge clk); #1;

        // acc returned to all-ones after the reset
        applyStimulus(3'd7, 16'h5555, 16'h0000, 1'b0, 16'h5555);

        // Flag patterns (the scoreboard expects zeros when flags are not built)
        applyStimulus(3'd0, 16'h8000, 16'h8001, 1'b0, 16'h8000);
        applyStimulus(3'd2, 16'h3C3C, 16'h3C3C, 1'b0, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
